seq1011_scan_ctrl: RTL and testbench

Scan controller that sequences the serial "1011" detector datapath. It accepts parallel words over a valid/ready handshake and serializes each word MSB-first, one bit per clock. The bits go both to an embedded copy of the overlapping Moore 1011 detector and out on bit_out/bit_vld, so an external detector instance can be driven in lockstep. It counts the matches in each word and reports the count with a one-cycle done pulse.

---
 rtl/seq1011_scan_ctrl.sv | 129 ++++++++++++
 tb/tb_seq1011_scan_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/seq1011_scan_ctrl.sv
// Scan controller: serializes accepted words MSB-first through an overlapping Moore 1011 detector.
// Optional macro SCAN_KEEP_HIST_EN keeps detector history across word boundaries.
module seq1011_scan_ctrl #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 3
) (
    input  logic              clk,
    input  logic              rs,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              bit_out,
    output logic              bit_vld,
    output logic              match,
    output logic              done,
    output logic [CNT_W-1:0]  match_cnt,
    output logic              busy
);

    localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } ctrl_e;

    typedef enum logic [2:0] {
        DetS0,
        DetS1,
        DetS2,
        DetS3,
        DetS4
    } det_e;

    ctrl_e             state_q, state_d;
    det_e              det_q, det_d, det_step;
    logic [DATA_W-1:0] word_q, word_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              accept;

    // Detector transition for the bit currently presented on bit_out.
    always_comb begin
        det_step = DetS0;
        unique case (det_q)
            DetS0:   det_step = bit_out ? DetS1 : DetS0;
            DetS1:   det_step = bit_out ? DetS1 : DetS2;
            DetS2:   det_step = bit_out ? DetS3 : DetS0;
            DetS3:   det_step = bit_out ? DetS4 : DetS2;
            DetS4:   det_step = bit_out ? DetS1 : DetS2;
            default: det_step = DetS0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        det_d     = det_q;
        word_d    = word_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        bit_out   = 1'b0;
        bit_vld   = 1'b0;
        match     = 1'b0;
        done      = 1'b0;
        busy      = 1'b0;
        accept    = 1'b0;
        match_cnt = cnt_q;

        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                accept   = in_valid;
                if (accept) begin
                    word_d  = in_data;
                    idx_d   = IDX_TOP;
                    cnt_d   = '0;
                    state_d = StShift;
`ifndef SCAN_KEEP_HIST_EN
                    det_d   = DetS0;
`endif
                end
            end
            StShift: begin
                busy    = 1'b1;
                bit_vld = 1'b1;
                bit_out = word_q[idx_q];
                match   = (det_step == DetS4);
                det_d   = det_step;
                if (match && (cnt_q != CNT_MAX)) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (idx_q == '0) begin
                    state_d = StDone;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            StDone: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rs) begin
            state_q <= StIdle;
            det_q   <= DetS0;
            word_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            det_q   <= det_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_seq1011_scan_ctrl.sv
// Directed self-checking bench for seq1011_scan_ctrl; a CNT_W=1 copy checks counter saturation.
module tb_seq1011_scan_ctrl;

    logic       clk;
    logic       rs;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready, bit_out, bit_vld, match, done, busy;
    logic [2:0] match_cnt;
    logic       s_in_ready, s_bit_out, s_bit_vld, s_match, s_done, s_busy;
    logic [0:0] s_match_cnt;

    int checks   = 0;
    int failures = 0;

    seq1011_scan_ctrl #(.DATA_W(8), .CNT_W(3)) dut (
        .clk(clk), .rs(rs), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .bit_out(bit_out), .bit_vld(bit_vld), .match(match),
        .done(done), .match_cnt(match_cnt), .busy(busy)
    );

    seq1011_scan_ctrl #(.DATA_W(8), .CNT_W(1)) dut_sat (
        .clk(clk), .rs(rs), .in_valid(in_valid), .in_data(in_data),
        .in_ready(s_in_ready), .bit_out(s_bit_out), .bit_vld(s_bit_vld), .match(s_match),
        .done(s_done), .match_cnt(s_match_cnt), .busy(s_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a word, wait for acceptance, then follow the scan to done.
    // hold keeps in_valid high and scrambles in_data during the scan.
    task automatic send(input logic [7:0] d, input bit hold,
                        output int cnt, output int lat, output int mpos, output int sat);
        int n;
        int bitn;
        in_data  = d;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 40) begin
            step();
            n++;
        end
        lat  = 0;
        bitn = 0;
        mpos = 0;
        cnt  = -1;
        sat  = -1;
        while (lat < 40) begin
            step();
            lat++;
            if (hold) in_data = in_data ^ 8'hFF;
            else      in_valid = 1'b0;
            if (bit_vld) begin
                bitn++;
                if (match) mpos = mpos | (1 << bitn);
            end
            if (done) begin
                cnt = int'(match_cnt);
                sat = int'(s_match_cnt);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    int cnt, lat, mpos, sat, gap, done_seen;
    int exp_hist;

    initial begin
        rs       = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) step();
        rs = 1'b0;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_bit_out", int'(bit_out), 0);
        check("rst_bit_vld", int'(bit_vld), 0);
        check("rst_match", int'(match), 0);
        check("rst_done", int'(done), 0);
        check("rst_cnt", int'(match_cnt), 0);
        check("rst_busy", int'(busy), 0);

        // 0xB0: single match on the 4th shifted bit
        send(8'hB0, 1'b0, cnt, lat, mpos, sat);
        check("b0_cnt", cnt, 1);
        check("b0_lat", lat, 9);
        check("b0_mpos", mpos, 1 << 4);
        step();
        check("b0_ready_after", int'(in_ready), 1);
        check("b0_cnt_hold", int'(match_cnt), 1);

        // 0xB6: overlapping matches on bits 4 and 7; CNT_W=1 copy saturates
        send(8'hB6, 1'b0, cnt, lat, mpos, sat);
        check("b6_cnt", cnt, 2);
        check("b6_mpos", mpos, (1 << 4) | (1 << 7));
        check("b6_sat_cnt", sat, 1);

        // 0x01 then 0x60 back-to-back with in_valid held
        step();
        send(8'h01, 1'b1, cnt, lat, mpos, sat);
        check("w01_cnt", cnt, 0);
        in_data  = 8'h60;
        in_valid = 1'b1;
        gap = 9;
        while (!in_ready && gap < 40) begin
            step();
            gap++;
        end
        check("b2b_gap", gap, 10);
`ifdef SCAN_KEEP_HIST_EN
        exp_hist = 1;
`else
        exp_hist = 0;
`endif
        send(8'h60, 1'b0, cnt, lat, mpos, sat);
        check("w60_cnt", cnt, exp_hist);

        // in_data scrambled during scan must not be re-latched
        step();
        send(8'hB0, 1'b1, cnt, lat, mpos, sat);
        check("hold_cnt", cnt, 1);
        check("hold_mpos", mpos, 1 << 4);

        // mid-scan reset at the 3rd SHIFT cycle of 0xBB
        step();
        in_data  = 8'hBB;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("bb_ready_low", int'(in_ready), 0);
        step();
        step();
        rs = 1'b1;
        step();
        rs = 1'b0;
        check("mrst_ready", int'(in_ready), 1);
        check("mrst_busy", int'(busy), 0);
        check("mrst_cnt", int'(match_cnt), 0);
        check("mrst_vld", int'(bit_vld), 0);
        done_seen = 0;
        repeat (12) begin
            step();
            if (done) done_seen = 1;
        end
        check("mrst_no_done", done_seen, 0);
        send(8'hB0, 1'b0, cnt, lat, mpos, sat);
        check("post_rst_cnt", cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
